// File: rtl/cycle_countdown.sv
// Loadable down-counter that times a phase and pulses done at terminal count.
// Define COUNTDOWN_AUTORELOAD_EN to restart from the last loaded value at terminal count.
module cycle_countdown #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             pause,
    input  logic             cancel,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done
);

    // Load handshake: a load transfers on a rising edge where load_valid && load_ready.
    // load_ready depends on the state register only; the source holds load_valid until then.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_d;

    // busy is the state register itself, so it also serves as the FSM debug view.
    assign busy       = (state_q == RUN);
    assign load_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            Q        <= '0;
            reload_q <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            Q        <= q_d;
            reload_q <= reload_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = Q;
        reload_d = reload_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    if (load_value == '0) begin
                        done_d = 1'b1;
                    end else begin
                        q_d      = load_value;
                        reload_d = load_value;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    q_d     = '0;
                    state_d = IDLE;
                end else if (!pause) begin
                    // Terminal test at Q=1 keeps the decrement from wrapping.
                    if (Q == WIDTH'(1)) begin
                        done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        q_d    = reload_q;
`else
                        q_d     = '0;
                        state_d = IDLE;
`endif
                    end else begin
                        q_d = Q - WIDTH'(1);
                    end
                end
            end
            default: begin
                q_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
